// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: turns hazard, redirect, memory-wait and debug run/step
// inputs into per-stage enables/flushes, drains after HALT, keeps counters.
module pipeline_ctrl #(
    parameter int NB_CNT       = 32,
    parameter int NB_DRAIN     = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_step,
    input  logic              i_hazard,
    input  logic              i_branch_taken,
    input  logic              i_jump,
    input  logic              i_halt_instr,
    input  logic              i_mem_busy,
    output logic              o_pc_we,
    output logic              o_if_id_we,
    output logic              o_if_id_flush,
    output logic              o_id_ex_flush,
    output logic              o_pipe_en,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_cycle_count,
    output logic [NB_CNT-1:0] o_stall_count
);

    // state  | meaning
    // IDLE   | debug unit holds pipeline, all controls low
    // RUN    | free-running active cycles while i_enable is high
    // STEP   | exactly one active cycle, then back to IDLE
    // DRAIN  | HALT left ID, retiring older instructions through WB
    // HALTED | drained, sticky until reset
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES);
    localparam logic [NB_DRAIN-1:0] DRAIN_ONE  = NB_DRAIN'(1);
    localparam logic [NB_CNT-1:0]   CNT_ONE    = NB_CNT'(1);

    state_t              state_q, state_d;
    logic [NB_DRAIN-1:0] drain_q, drain_d;
    logic [NB_CNT-1:0]   cycle_q, cycle_d;
    logic [NB_CNT-1:0]   stall_q, stall_d;
    logic                halted_q, halted_d;

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        cycle_d       = cycle_q;
        stall_d       = stall_q;
        halted_d      = halted_q;
        o_pc_we       = 1'b0;
        o_if_id_we    = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_pipe_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                if (state_q == ST_STEP || !i_enable) begin
                    state_d = ST_IDLE;
                end
                if (i_mem_busy) begin
                    stall_d = stall_q + CNT_ONE;
                end else begin
                    cycle_d   = cycle_q + CNT_ONE;
                    o_pipe_en = 1'b1;
                    // A load-use bubble masks redirects and HALT: operands not ready yet.
                    if (i_hazard) begin
                        o_id_ex_flush = 1'b1;
                        stall_d       = stall_q + CNT_ONE;
                    end else if (i_halt_instr) begin
                        o_if_id_flush = 1'b1;
                        drain_d       = DRAIN_LOAD;
                        state_d       = ST_DRAIN;
                    end else begin
                        o_pc_we       = 1'b1;
                        o_if_id_we    = 1'b1;
                        o_if_id_flush = i_branch_taken | i_jump;
                    end
                end
            end

            ST_DRAIN: begin
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
                o_pipe_en     = ~i_mem_busy;
                if (!i_mem_busy) begin
                    drain_d = drain_q - DRAIN_ONE;
                    if (drain_q == DRAIN_ONE) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            drain_q  <= '0;
            cycle_q  <= '0;
            stall_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            cycle_q  <= cycle_d;
            stall_q  <= stall_d;
            halted_q <= halted_d;
        end
    end

    assign o_halted      = halted_q;
    assign o_cycle_count = cycle_q;
    assign o_stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed test-plan scenarios plus random traffic,
// all checked every cycle against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int NB_CNT       = 32;
    localparam int NB_DRAIN     = 2;
    localparam int DRAIN_CYCLES = 3;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    logic i_enable = 1'b0, i_step = 1'b0, i_hazard = 1'b0, i_branch_taken = 1'b0;
    logic i_jump = 1'b0, i_halt_instr = 1'b0, i_mem_busy = 1'b0;
    logic o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_flush, o_pipe_en, o_halted;
    logic [NB_CNT-1:0] o_cycle_count, o_stall_count;

    int checks   = 0;
    int failures = 0;

    // behavioural model
    string       mode;
    int          drain_left;
    logic [31:0] m_cycle, m_stall;
    bit          m_halted;

    pipeline_ctrl #(
        .NB_CNT(NB_CNT), .NB_DRAIN(NB_DRAIN), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_step(i_step),
        .i_hazard(i_hazard), .i_branch_taken(i_branch_taken), .i_jump(i_jump),
        .i_halt_instr(i_halt_instr), .i_mem_busy(i_mem_busy),
        .o_pc_we(o_pc_we), .o_if_id_we(o_if_id_we), .o_if_id_flush(o_if_id_flush),
        .o_id_ex_flush(o_id_ex_flush), .o_pipe_en(o_pipe_en), .o_halted(o_halted),
        .o_cycle_count(o_cycle_count), .o_stall_count(o_stall_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t mode=%s", name, act, exp, $time, mode);
        end
    endtask

    task automatic model_reset();
        mode       = "idle";
        drain_left = 0;
        m_cycle    = 0;
        m_stall    = 0;
        m_halted   = 0;
    endtask

    // Work out this cycle's controls from the rules, compare, then advance the model.
    task automatic model_cycle();
        bit          e_pc = 0, e_ifwe = 0, e_iff = 0, e_idf = 0, e_pe = 0;
        string       nxt = mode;
        logic [31:0] nc = m_cycle, ns = m_stall;
        bit          nh = m_halted;

        if (mode == "idle") begin
            if (i_enable) nxt = "run";
            else if (i_step) nxt = "step";
        end else if (mode == "run" || mode == "step") begin
            nxt = (mode == "run" && i_enable) ? "run" : "idle";
            if (i_mem_busy) begin
                ns = m_stall + 1;
            end else begin
                nc   = m_cycle + 1;
                e_pe = 1;
                if (i_hazard) begin
                    e_idf = 1;
                    ns    = m_stall + 1;
                end else if (i_halt_instr) begin
                    e_iff      = 1;
                    drain_left = DRAIN_CYCLES;
                    nxt        = "drain";
                end else begin
                    e_pc   = 1;
                    e_ifwe = 1;
                    e_iff  = i_branch_taken | i_jump;
                end
            end
        end else if (mode == "drain") begin
            e_iff = 1;
            e_idf = 1;
            e_pe  = !i_mem_busy;
            if (!i_mem_busy) begin
                drain_left--;
                if (drain_left == 0) begin
                    nxt = "halted";
                    nh  = 1;
                end
            end
        end

        chk("pc_we", 32'(o_pc_we), 32'(e_pc));
        chk("if_id_we", 32'(o_if_id_we), 32'(e_ifwe));
        chk("if_id_flush", 32'(o_if_id_flush), 32'(e_iff));
        chk("id_ex_flush", 32'(o_id_ex_flush), 32'(e_idf));
        chk("pipe_en", 32'(o_pipe_en), 32'(e_pe));
        chk("halted", 32'(o_halted), 32'(m_halted));
        chk("cycle_count", o_cycle_count, m_cycle);
        chk("stall_count", o_stall_count, m_stall);

        mode     = nxt;
        m_cycle  = nc;
        m_stall  = ns;
        m_halted = nh;
    endtask

    // Inputs change at posedge+1, are checked at negedge, task returns at posedge+1.
    task automatic run_cycle(input bit en, input bit st, input bit hz, input bit br,
                             input bit jp, input bit ht, input bit mb);
        i_enable = en; i_step = st; i_hazard = hz; i_branch_taken = br;
        i_jump = jp; i_halt_instr = ht; i_mem_busy = mb;
        @(negedge i_clock);
        model_cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        #2;
        model_reset();
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        chk("rst_cycle", o_cycle_count, 32'd0);
        chk("rst_stall", o_stall_count, 32'd0);
        chk("rst_halted", 32'(o_halted), 32'd0);

        // One IDLE cycle to enter RUN, then ten clean active cycles.
        for (int i = 0; i < 11; i++) run_cycle(1, 0, 0, 0, 0, 0, 0);
        chk("run10_cycle", o_cycle_count, 32'd10);
        chk("run10_stall", o_stall_count, 32'd0);

        run_cycle(1, 0, 1, 1, 0, 0, 0);
        chk("hazard_cycle", o_cycle_count, 32'd11);
        chk("hazard_stall", o_stall_count, 32'd1);

        for (int i = 0; i < 4; i++) run_cycle(1, 0, 1, 0, 0, 0, 1);
        chk("busy_cycle", o_cycle_count, 32'd11);
        chk("busy_stall", o_stall_count, 32'd5);

        run_cycle(1, 0, 0, 0, 1, 0, 0);
        chk("jump_cycle", o_cycle_count, 32'd12);

        // HALT, then drain with one frozen cycle: halted appears 5 cycles after HALT.
        run_cycle(1, 0, 0, 0, 0, 1, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 1);
        run_cycle(1, 0, 1, 1, 0, 1, 0);
        chk("drain_not_yet", 32'(o_halted), 32'd0);
        run_cycle(0, 1, 0, 0, 0, 0, 0);
        chk("halted_set", 32'(o_halted), 32'd1);
        chk("halt_cycle", o_cycle_count, 32'd13);
        chk("halt_stall", o_stall_count, 32'd5);
        for (int i = 0; i < 6; i++) run_cycle(i[0], 0, 0, 0, 0, 0, 0);
        chk("halted_sticky", 32'(o_halted), 32'd1);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 1, 0, 0, 0, 0, 0);
            run_cycle(0, 0, 0, 0, 0, 0, 0);
            run_cycle(0, 0, 0, 0, 0, 0, 0);
        end
        chk("step3_cycle", o_cycle_count, 32'd3);

        // Asynchronous reset while draining.
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 1, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0);
        i_reset = 1'b1;
        #1;
        chk("arst_if_id_flush", 32'(o_if_id_flush), 32'd0);
        chk("arst_id_ex_flush", 32'(o_id_ex_flush), 32'd0);
        chk("arst_cycle", o_cycle_count, 32'd0);
        chk("arst_stall", o_stall_count, 32'd0);
        model_reset();
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        run_cycle(0, 0, 0, 0, 0, 0, 0);
        chk("arst_idle_pc_we", 32'(o_pc_we), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                run_cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 4) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
